// File: rtl/lector_entradas_pkg.sv
// Shared constants for the memory-mapped input peripheral: register
// addresses and the default debounce window (2.5 ms at 100 MHz).
package lector_entradas_pkg;

  localparam logic [1:0] DIR_SW      = 2'd0;
  localparam logic [1:0] DIR_EVENTO  = 2'd1;
  localparam logic [1:0] DIR_BTN     = 2'd2;
  localparam logic [1:0] DIR_MASCARA = 2'd3;

  localparam int DEBOUNCE_DEFAULT = 250000;

endpackage

// File: rtl/lector_entradas_antirrebote.sv
// One input bit: two-flop synchronizer followed by a debounce counter that
// accepts a new level only after it has held for DEBOUNCE_CYCLES clocks.
module antirrebote
  import lector_entradas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic raw_i,
  output logic nivel_o,
  output logic subida_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic meta;
  logic sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw_i;
      sync <= meta;
    end
  end

  // Any return to the stable level restarts the count, so glitches never land.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      nivel_o <= 1'b0;
      cnt     <= '0;
    end else if (sync == nivel_o) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      nivel_o <= sync;
      cnt     <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Combinational so the event register can set on the same edge as nivel_o.
  assign subida_o = sync & ~nivel_o & (cnt == CNT_MAX);

endmodule

// File: rtl/lector_entradas.sv
// Input peripheral for the RISC-V core: debounced switches and buttons,
// sticky button-press events with W1C, an interrupt mask and a registered read port.
module lector_entradas
  import lector_entradas_pkg::*;
#(
  parameter int N_SW            = 16,
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [N_SW-1:0]  sw_i,
  input  logic [N_BTN-1:0] btn_i,
  input  logic [1:0]       addr_i,
  input  logic             we_i,
  input  logic [31:0]      dato_i,
  output logic [31:0]      dato_o,
  output logic             irq_o
);

  logic [N_SW-1:0]   d_sw;
  logic [N_SW-1:0]   unused_sw_subida;
  logic [N_BTN-1:0]  d_btn;
  logic [N_BTN-1:0]  btn_subida;
  logic [N_BTN-1:0]  evento;
  logic [N_BTN-1:0]  mask;
  logic [31:0]       leido;
  logic [31-N_BTN:0] unused_dato;

  assign unused_dato = dato_i[31:N_BTN];

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .raw_i    (sw_i[i]),
      .nivel_o  (d_sw[i]),
      .subida_o (unused_sw_subida[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .raw_i    (btn_i[i]),
      .nivel_o  (d_btn[i]),
      .subida_o (btn_subida[i])
    );
  end

  always_comb begin
    leido = '0;
    case (addr_i)
      DIR_SW:      leido = 32'(d_sw);
      DIR_EVENTO:  leido = 32'(evento);
      DIR_BTN:     leido = 32'(d_btn);
      DIR_MASCARA: leido = 32'(mask);
      default:     leido = '0;
    endcase
  end

  // A new press is OR-ed in after the W1C clear, so a colliding set wins.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      evento <= '0;
      mask   <= '0;
      dato_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (we_i && addr_i == DIR_EVENTO) begin
        evento <= (evento & ~dato_i[N_BTN-1:0]) | btn_subida;
      end else begin
        evento <= evento | btn_subida;
      end
      if (we_i && addr_i == DIR_MASCARA) begin
        mask <= dato_i[N_BTN-1:0];
      end
      irq_o  <= |(evento & mask);
      dato_o <= leido;
    end
  end

endmodule
